// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a small show-ahead byte FIFO.
// The serial line is synchronized and then sampled mid-bit by a baud counter.
// Good frames are pushed into a circular buffer that the core drains with rd_en.
module uart_rx_fifo #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   uart_rx,
  input  logic                   rd_en,
  output logic [7:0]             rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   frame_err,
  output logic                   overrun
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam int AW   = $clog2(DEPTH);

  localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  // Synchronizer and edge-detect flops
  logic sync1_q, sync2_q, rxs_prev_q;
  logic rxs;

  // Receive FSM state
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          push;
  logic          frame_err_q, frame_err_d;

  // FIFO state
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          pop, full, wr_en;
  logic          overrun_q, overrun_d;

  assign rxs = sync2_q;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection; all idle high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= uart_rx;
      sync2_q    <= sync1_q;
      rxs_prev_q <= sync2_q;
    end
  end

  // Receive FSM next state: half-bit wait to center on the start bit, then full-bit steps.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    idx_d       = idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rxs_prev_q && !rxs) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rxs) begin
            idx_d   = 3'd0;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == DIV_M1) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxs;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == DIV_M1) begin
          cnt_d = '0;
          if (rxs) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Receive FSM registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  // FIFO control: a pop frees the head slot in the same edge, so a push into a full FIFO is kept.
  always_comb begin
    full      = (count_q == FULL_LVL);
    pop       = rd_en && (count_q != '0);
    wr_en     = push && (!full || pop);
    overrun_d = push && full && !pop;
    wr_ptr_d  = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (!wr_en && pop) begin
      count_d = count_q - (AW + 1)'(1);
    end
  end

  // FIFO pointers, count and overrun pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Byte storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rd_data    = mem_q[rd_ptr_q];
  assign rd_valid   = (count_q != '0);
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed table, hand sequences and a
// randomized run against a queue-based reference of the received byte stream.
module tb_uart_rx_fifo;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int DEPTH  = 4;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int STOP_LAT = 155;  // frame start drive -> first cycle rd_valid/flag visible

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] fifo_count;
  logic       frame_err;
  logic       overrun;

  uart_rx_fifo #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .uart_rx   (uart_rx),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .fifo_count(fifo_count),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ferr_n = 0, ovr_n = 0;
  int ferr_cyc = -1, ovr_cyc = -1, rise_cyc = -1;
  logic rv_prev = 1'b0;
  int start_cyc = 0;
  logic [7:0] q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       pop_at_stop;
    int         exp_count;
    logic [7:0] exp_head;
    int         exp_ovr;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];
  logic [7:0] drain_exp[4];

  always @(posedge clk) cyc <= cyc + 1;

  // Flag pulse counters and rd_valid rise time, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_err) begin
      ferr_n   <= ferr_n + 1;
      ferr_cyc <= cyc;
    end
    if (overrun) begin
      ovr_n   <= ovr_n + 1;
      ovr_cyc <= cyc;
    end
    rv_prev <= rd_valid;
    if (rd_valid && !rv_prev) rise_cyc <= cyc;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare visible FIFO state against the reference queue.
  task automatic check_state(input string name);
    check({name, " count"}, int'(fifo_count), q.size());
    check({name, " valid"}, int'(rd_valid), int'(q.size() != 0));
    if (q.size() != 0) check({name, " head"}, int'(rd_data), int'(q[0]));
  endtask

  // Entered #1 after a clock edge; returns #1 after the edge ending the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic pop_at_stop);
    logic [9:0] bits;
    bits = {stop_b, d, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      if (i == 9 && pop_at_stop) begin
        repeat (DIV / 2 + 2) @(posedge clk);
        #1 rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        repeat (DIV - DIV / 2 - 3) @(posedge clk);
        #1;
      end else begin
        repeat (DIV) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, o0;
    logic [7:0] d;
    logic stb;
    int exp_ovr;

    vecs[0] = '{8'h00, 1'b1, 1'b0, 1, 8'h00, 0, 0};
    vecs[1] = '{8'hFF, 1'b1, 1'b0, 2, 8'h00, 0, 0};
    vecs[2] = '{8'h55, 1'b1, 1'b0, 3, 8'h00, 0, 0};
    vecs[3] = '{8'h81, 1'b1, 1'b0, 4, 8'h00, 0, 0};
    vecs[4] = '{8'h3C, 1'b1, 1'b0, 4, 8'h00, 1, 0};
    vecs[5] = '{8'h3C, 1'b1, 1'b1, 4, 8'hFF, 0, 0};
    drain_exp[0] = 8'hFF;
    drain_exp[1] = 8'h55;
    drain_exp[2] = 8'h81;
    drain_exp[3] = 8'h3C;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset valid", int'(rd_valid), 0);
    check("reset count", int'(fifo_count), 0);
    check("reset frame_err", int'(frame_err), 0);
    check("reset overrun", int'(overrun), 0);
    reset_n = 1'b1;
    idle(5);

    // Single byte with exact latency
    send_frame(8'hA5, 1'b1, 1'b0);
    q.push_back(8'hA5);
    $display("frame 0xa5 stop=1 count=%0d", fifo_count);
    check("single latency", rise_cyc - start_cyc, STOP_LAT);
    check_state("single");
    pop_one();
    check_state("single pop");
    pop_one();
    check_state("pop empty");

    // Back-to-back burst, overrun and pop-on-push from the table
    for (int i = 0; i < 6; i++) begin
      f0 = ferr_n;
      o0 = ovr_n;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].pop_at_stop);
      if (vecs[i].pop_at_stop && q.size() != 0) void'(q.pop_front());
      if (vecs[i].stop && q.size() < DEPTH) q.push_back(vecs[i].data);
      $display("vec %0d data=0x%02h pop=%0d count=%0d head=0x%02h", i, vecs[i].data,
               vecs[i].pop_at_stop, fifo_count, rd_data);
      check($sformatf("vec%0d count", i), int'(fifo_count), vecs[i].exp_count);
      check($sformatf("vec%0d valid", i), int'(rd_valid), 1);
      check($sformatf("vec%0d head", i), int'(rd_data), int'(vecs[i].exp_head));
      check($sformatf("vec%0d overrun", i), ovr_n - o0, vecs[i].exp_ovr);
      check($sformatf("vec%0d frame_err", i), ferr_n - f0, vecs[i].exp_ferr);
      if (vecs[i].exp_ovr != 0) check($sformatf("vec%0d ovr time", i), ovr_cyc - start_cyc, STOP_LAT);
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d", i), int'(rd_data), int'(drain_exp[i]));
      pop_one();
    end
    check_state("drained");

    // Framing error then recovery
    f0 = ferr_n;
    o0 = ovr_n;
    send_frame(8'h7E, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    idle(4);
    $display("frame 0x7e stop=0 frame_err pulses=%0d", ferr_n - f0);
    check("ferr pulse", ferr_n - f0, 1);
    check("ferr time", ferr_cyc - start_cyc, STOP_LAT);
    check("ferr no ovr", ovr_n - o0, 0);
    check_state("ferr no push");
    send_frame(8'h12, 1'b1, 1'b0);
    q.push_back(8'h12);
    $display("frame 0x12 stop=1 count=%0d", fifo_count);
    check_state("after ferr");
    check("after ferr flags", ferr_n - f0, 1);
    pop_one();

    // Glitch rejection
    f0 = ferr_n;
    o0 = ovr_n;
    uart_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(30);
    $display("glitch 4 cycles count=%0d", fifo_count);
    check_state("glitch");
    check("glitch flags", (ferr_n - f0) + (ovr_n - o0), 0);
    send_frame(8'h5A, 1'b1, 1'b0);
    q.push_back(8'h5A);
    $display("frame 0x5a stop=1 count=%0d", fifo_count);
    check_state("post glitch");

    // Reset during bit 3 of 0xC3 with a byte still held
    uart_rx = 1'b0;
    repeat (DIV) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      d = 8'hC3;
      uart_rx = d[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
    d = 8'hC3;
    uart_rx = d[3];
    repeat (DIV / 2) @(posedge clk);
    #1 reset_n = 1'b0;
    uart_rx = 1'b1;
    #2;
    check("async rst valid", int'(rd_valid), 0);
    check("async rst count", int'(fifo_count), 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst frame_err", int'(frame_err), 0);
    check("rst overrun", int'(overrun), 0);
    reset_n = 1'b1;
    q.delete();
    idle(20);
    check_state("after rst");
    send_frame(8'h99, 1'b1, 1'b0);
    q.push_back(8'h99);
    $display("frame 0x99 stop=1 count=%0d", fifo_count);
    check_state("post rst frame");
    pop_one();
    idle(3);

    // Randomized frames, pops and gaps against the queue model
    for (int t = 0; t < 30; t++) begin
      int npop;
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) begin
        check_state($sformatf("rnd%0d prepop", t));
        pop_one();
      end
      d   = 8'($urandom);
      stb = ($urandom_range(0, 7) != 0);
      f0  = ferr_n;
      o0  = ovr_n;
      exp_ovr = (stb && q.size() == DEPTH) ? 1 : 0;
      send_frame(d, stb, 1'b0);
      if (stb && q.size() < DEPTH) q.push_back(d);
      $display("rnd %0d data=0x%02h stop=%0d pops=%0d count=%0d", t, d, stb, npop, fifo_count);
      check($sformatf("rnd%0d frame_err", t), ferr_n - f0, int'(!stb));
      check($sformatf("rnd%0d overrun", t), ovr_n - o0, exp_ovr);
      check_state($sformatf("rnd%0d", t));
      if (!stb) begin
        repeat ($urandom_range(0, 30)) @(posedge clk);
        #1;
        idle($urandom_range(2, 6));
      end else begin
        idle($urandom_range(0, 12));
      end
    end
    while (q.size() != 0) begin
      check_state("rnd drain");
      pop_one();
    end
    check_state("rnd empty");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
